// File: rtl/si_mac_accumulator_quant.sv
// ----------------------------------------------------------------------------
// si_mac_accumulator_quant
//   Sequential int8 multiply-accumulate stage of one quantized neuron.
//   (activation, weight) beats arrive over a valid/ready handshake. Each beat
//   has the activation zero point removed and is multiplied by its weight
//   (stage 1). The product is then added onto a per-vector bias or the running
//   sum, with saturation to the N_ACC-bit signed range (stage 2). The result is
//   held on a valid/ready output until the consumer takes it.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      input beat valid
//   in_ready      beat accepted on a clk edge when in_valid & in_ready
//   in_act, in_w  signed N_IN-bit activation and weight
//   in_last       final beat of the vector
//   bias          signed N_ACC-bit bias, sampled on the first beat only
//   out_valid     result valid, held until out_ready
//   out_ready     consumer takes the result when out_valid & out_ready
//   out_acc       signed saturated sum bias + sum((act - ZP_IN) * w)
//   out_sat       saturation happened somewhere in this vector
//   out_len_err   vector was closed by MAX_LEN rather than in_last
//   out_count     number of beats accumulated in this vector
// ----------------------------------------------------------------------------
module si_mac_accumulator_quant #(
    parameter int N_IN    = 8,
    parameter int N_ACC   = 32,
    parameter int ZP_IN   = 0,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_act,
    input  logic [N_IN-1:0]         in_w,
    input  logic                    in_last,
    input  logic [N_ACC-1:0]        bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_ACC-1:0]        out_acc,
    output logic                    out_sat,
    output logic                    out_len_err,
    output logic [CNT_W-1:0]        out_count
);

    // (act - ZP_IN) needs two extra bits so any zero point stays exact.
    localparam int D_W   = N_IN + 2;
    localparam int P_W   = 2 * N_IN + 2;
    // Sum is one bit wider than the wider operand so overflow is visible.
    localparam int SUM_W = ((N_ACC > P_W) ? N_ACC : P_W) + 1;

    localparam logic signed [N_ACC-1:0] ACC_MAX = {1'b0, {(N_ACC-1){1'b1}}};
    localparam logic signed [N_ACC-1:0] ACC_MIN = {1'b1, {(N_ACC-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_first_q, s1_first_d;
    logic signed [P_W-1:0]   p_q, p_d;
    logic signed [N_ACC-1:0] bias_q, bias_d;
    logic signed [N_ACC-1:0] acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic                    len_err_q, len_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic                    first_beat;
    logic                    hit_max;
    logic                    close_vec;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [D_W-1:0]   act_ext, zp_ext, diff;
    logic signed [P_W-1:0]   prod;
    logic signed [N_ACC-1:0] base;
    logic signed [SUM_W-1:0] sum;
    logic                    over, under;
    logic signed [N_ACC-1:0] acc_clamped;

    // Reset forces in_ready low so nothing is accepted in the reset cycle.
    assign in_ready = !rst && (state_q == S_IDLE || state_q == S_ACC);
    assign accept   = in_valid && in_ready;

    assign out_valid   = (state_q == S_OUT);
    assign out_acc     = acc_q;
    assign out_sat     = sat_q;
    assign out_len_err = len_err_q;
    // The beat counter is frozen from the closing beat until the next vector.
    assign out_count   = cnt_q;

    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        s1_first_d = s1_first_q;
        p_d        = p_q;
        bias_d     = bias_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        len_err_d  = len_err_q;
        cnt_d      = cnt_q;

        // ---- stage 1: zero-point removal and exact multiply ----
        first_beat = (state_q == S_IDLE);
        cnt_next   = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
        hit_max    = (cnt_next == CNT_W'(MAX_LEN));
        close_vec  = in_last || hit_max;
        act_ext    = D_W'($signed(in_act));
        zp_ext     = D_W'(ZP_IN);
        diff       = act_ext - zp_ext;
        prod       = P_W'(diff) * P_W'($signed(in_w));

        if (accept) begin
            p_d        = prod;
            s1_first_d = first_beat;
            cnt_d      = cnt_next;
            // Only the MAX_LEN-th beat without in_last flags a length error.
            len_err_d  = hit_max && !in_last;
            if (first_beat) begin
                bias_d = $signed(bias);
            end
        end

        // ---- stage 2: saturating accumulate ----
        base  = s1_first_q ? bias_q : acc_q;
        sum   = SUM_W'(base) + SUM_W'(p_q);
        over  = (sum > SUM_W'(ACC_MAX));
        under = (sum < SUM_W'(ACC_MIN));
        if (over) begin
            acc_clamped = ACC_MAX;
        end else if (under) begin
            acc_clamped = ACC_MIN;
        end else begin
            acc_clamped = sum[N_ACC-1:0];
        end

        if (s1_valid_q) begin
            acc_d = acc_clamped;
            sat_d = (s1_first_q ? 1'b0 : sat_q) || over || under;
        end

        // ---- vector framing ----
        unique case (state_q)
            S_IDLE, S_ACC: begin
                if (accept) begin
                    state_d = close_vec ? S_DRAIN : S_ACC;
                end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            len_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            len_err_q  <= len_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: pure datapath registers are not reset; they are only consumed
    // when their qualifying valid/first flag, which is reset, says so.
    always_ff @(posedge clk) begin
        p_q    <= p_d;
        bias_q <= bias_d;
    end

endmodule
